seg7_scan_driver: RTL and testbench

- Downstream consumer of the traffic-light controller's four BCD digit outputs (bcd3..bcd0).
- Time-multiplexes the four digits onto one shared 7-segment bus with one-hot digit enables.
- Decodes 0-9, dash (4'hF) and blank (4'hA-4'hE).
- Snapshots inputs once per frame so a digit never tears mid-frame; drives board pins directly.

---
 rtl/seg7_scan_driver.sv | 136 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed 7-segment driver with per-frame input snapshot and anti-ghost enable timing.
// Optional brightness control (input bright) is enabled by defining SEG_DIM_EN.
module seg7_scan_driver #(
    parameter int SCAN_DIV       = 125000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd0,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd3,
    input  logic [3:0] dp_in,
`ifdef SEG_DIM_EN
    input  logic [2:0] bright,
`endif
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_tick
);

    localparam int             PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]  CNT_MAX = PW'(SCAN_DIV - 1);
    localparam logic [6:0]     SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic           DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [3:0]     AN_OFF  = {4{AN_ACTIVE_LOW}};

    logic [PW-1:0] cnt;
    logic [PW-1:0] cnt_next;
    logic [1:0]    idx;
    logic [1:0]    idx_next;
    logic [3:0]    sh0, sh1, sh2, sh3;
    logic [3:0]    sh_dp;
    logic          live;
    logic          tick;
    logic          wrap;
    logic          an_on;
    logic          an_en;
    logic [3:0]    code;
    logic          dp_sel;
    logic [3:0]    one_hot;
    logic [3:0]    an_next;

    function automatic logic [6:0] decode(input logic [3:0] c);
        case (c)
            4'h0:    decode = 7'b0111111;
            4'h1:    decode = 7'b0000110;
            4'h2:    decode = 7'b1011011;
            4'h3:    decode = 7'b1001111;
            4'h4:    decode = 7'b1100110;
            4'h5:    decode = 7'b1101101;
            4'h6:    decode = 7'b1111101;
            4'h7:    decode = 7'b0000111;
            4'h8:    decode = 7'b1111111;
            4'h9:    decode = 7'b1101111;
            4'hF:    decode = 7'b1000000;
            default: decode = 7'b0000000;
        endcase
    endfunction

    assign tick     = (cnt == CNT_MAX);
    assign wrap     = tick && (idx == 2'd3);
    assign cnt_next = tick ? '0 : cnt + PW'(1);
    assign idx_next = idx + 2'd1;

    // On the wrap edge the shadow is being loaded, so slot 0 takes its code from the inputs directly.
    always_comb begin
        code   = 4'hA;
        dp_sel = 1'b0;
        if (wrap) begin
            code   = bcd0;
            dp_sel = dp_in[0];
        end else begin
            case (idx_next)
                2'd0:    begin code = sh0; dp_sel = sh_dp[0]; end
                2'd1:    begin code = sh1; dp_sel = sh_dp[1]; end
                2'd2:    begin code = sh2; dp_sel = sh_dp[2]; end
                default: begin code = sh3; dp_sel = sh_dp[3]; end
            endcase
        end
    end

`ifdef SEG_DIM_EN
    logic [31:0] lim;
    always_comb begin
        lim   = ((32'(bright) + 32'd1) * 32'(SCAN_DIV)) / 32'd8;
        an_on = (cnt_next != '0) && (32'(cnt_next) < lim);
    end
`else
    assign an_on = (cnt_next != '0);
`endif

    // Enable is computed for the next cycle: off at slot start (cnt_next == 0), on from cnt 1.
    always_comb begin
        one_hot = 4'b0001 << idx;
        an_en   = live && an_on;
        an_next = an_en ? (AN_OFF ^ one_hot) : AN_OFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            sh0        <= 4'hA;
            sh1        <= 4'hA;
            sh2        <= 4'hA;
            sh3        <= 4'hA;
            sh_dp      <= '0;
            live       <= 1'b0;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= cnt_next;
            frame_tick <= wrap;
            an         <= an_next;
            if (tick) begin
                idx <= idx_next;
                seg <= SEG_OFF ^ decode(code);
                dp  <= DP_OFF ^ dp_sel;
            end
            if (wrap) begin
                sh0   <= bcd0;
                sh1   <= bcd1;
                sh2   <= bcd2;
                sh3   <= bcd3;
                sh_dp <= dp_in;
                live  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver (SCAN_DIV = 8, active-low pins).
// Define SEG_DIM_EN to also exercise the brightness window.
module tb_seg7_scan_driver;

    localparam int SD = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd0, bcd1, bcd2, bcd3, dp_in;
`ifdef SEG_DIM_EN
    logic [2:0] bright = 3'd7;
`endif
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
    } exp_t;

    exp_t sb[$];
    exp_t cur;

    seg7_scan_driver #(
        .SCAN_DIV(SD),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bcd0(bcd0),
        .bcd1(bcd1),
        .bcd2(bcd2),
        .bcd3(bcd3),
        .dp_in(dp_in),
`ifdef SEG_DIM_EN
        .bright(bright),
`endif
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] c);
        case (c)
            4'h0:    return 7'b0111111;
            4'h1:    return 7'b0000110;
            4'h2:    return 7'b1011011;
            4'h3:    return 7'b1001111;
            4'h4:    return 7'b1100110;
            4'h5:    return 7'b1101101;
            4'h6:    return 7'b1111101;
            4'h7:    return 7'b0000111;
            4'h8:    return 7'b1111111;
            4'h9:    return 7'b1101111;
            4'hF:    return 7'b1000000;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [3:0] d3, input logic [3:0] d2,
                              input logic [3:0] d1, input logic [3:0] d0,
                              input logic [3:0] dpv);
        exp_t       e;
        logic [3:0] c;
        logic [3:0] oh;
        for (int s = 0; s < 4; s++) begin
            case (s)
                0:       c = d0;
                1:       c = d1;
                2:       c = d2;
                default: c = d3;
            endcase
            oh     = 4'b0001;
            oh     = oh << s;
            e.seg  = ~ref_seg(c);
            e.dp   = ~dpv[s];
            e.an   = ~oh;
            sb.push_back(e);
        end
    endtask

    // Entered right after the slot's first edge (prescaler 0); leaves at prescaler 4.
    task automatic slot_head(input int s);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=entry");
            cur = '0;
        end else begin
            cur = sb.pop_front();
        end
        chk("ghost_an", {4'h0, an}, 8'h0F);
        chk("slot_seg", {1'b0, seg}, {1'b0, cur.seg});
        chk("slot_dp", {7'h0, dp}, {7'h0, cur.dp});
        chk("frame_tick_slot", {7'h0, frame_tick}, 8'(s == 0));
        step(1);
        chk("an_onehot", {4'h0, an}, {4'h0, cur.an});
        chk("frame_tick_low", {7'h0, frame_tick}, 8'h00);
        step(3);
    endtask

    task automatic slot_tail();
        step(3);
        chk("an_hold", {4'h0, an}, {4'h0, cur.an});
        chk("seg_hold", {1'b0, seg}, {1'b0, cur.seg});
        chk("dp_hold", {7'h0, dp}, {7'h0, cur.dp});
        step(1);
    endtask

    task automatic slot(input int s);
        slot_head(s);
        slot_tail();
    endtask

    // From reset release up to the first snapshot edge (edge 4*SD).
    task automatic blank_run();
        for (int e = 1; e < 4 * SD; e++) begin
            step(1);
            chk("pre_an_off", {4'h0, an}, 8'h0F);
            chk("pre_no_tick", {7'h0, frame_tick}, 8'h00);
            chk("pre_seg_blank", {1'b0, seg}, 8'h7F);
            chk("pre_dp_off", {7'h0, dp}, 8'h01);
        end
        step(1);
    endtask

    initial begin
        bcd3  = 4'h1;
        bcd2  = 4'hF;
        bcd1  = 4'h0;
        bcd0  = 4'h3;
        dp_in = 4'b0000;
        step(3);
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dp", {7'h0, dp}, 8'h01);
        chk("rst_an", {4'h0, an}, 8'h0F);
        chk("rst_ft", {7'h0, frame_tick}, 8'h00);
        rst = 1'b0;
        push_frame(4'h1, 4'hF, 4'h0, 4'h3, 4'b0000);
        blank_run();

        // Frame 1: traffic pattern; bcd3/bcd0 change mid-frame must not show until the next frame.
        slot_head(0);
        bcd3 = 4'h9;
        slot_tail();
        slot(1);
        slot_head(2);
        bcd0 = 4'h2;
        push_frame(4'h9, 4'hF, 4'h0, 4'h2, 4'b0000);
        slot_tail();
        slot(3);

        // Frame 2: change during slot 0 itself must not tear the visible digit.
        slot_head(0);
        bcd0 = 4'h4;
        slot_tail();
        slot(1);
        slot(2);
        slot_head(3);
        bcd0  = 4'hA;
        dp_in = 4'b0100;
        push_frame(4'h9, 4'hF, 4'h0, 4'hA, 4'b0100);
        slot_tail();

        // Frames 3..7: blank codes A..E in turn, then digit 8 with dp on slot 0.
        for (int k = 0; k < 5; k++) begin
            slot(0);
            slot(1);
            slot(2);
            slot_head(3);
            if (k < 4) begin
                bcd0  = 4'(11 + k);
                dp_in = 4'b0000;
                push_frame(4'h9, 4'hF, 4'h0, 4'(11 + k), 4'b0000);
            end else begin
                bcd0  = 4'h8;
                dp_in = 4'b0001;
                push_frame(4'h9, 4'hF, 4'h0, 4'h8, 4'b0001);
            end
            slot_tail();
        end

        // Frame 8: asynchronous reset in the middle of a lit slot.
        slot_head(0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_seg", {1'b0, seg}, 8'h7F);
        chk("async_rst_dp", {7'h0, dp}, 8'h01);
        chk("async_rst_an", {4'h0, an}, 8'h0F);
        chk("async_rst_ft", {7'h0, frame_tick}, 8'h00);
        sb.delete();
        step(2);
        chk("held_rst_an", {4'h0, an}, 8'h0F);
        rst = 1'b0;
        push_frame(4'h9, 4'hF, 4'h0, 4'h8, 4'b0001);
        blank_run();
        for (int s = 0; s < 4; s++) slot(s);

`ifdef SEG_DIM_EN
        bright = 3'd3;
        chk("dim_cnt0", {4'h0, an}, 8'h0F);
        for (int k = 1; k < SD; k++) begin
            step(1);
            chk("dim_window", {4'h0, an}, (k <= 3) ? 8'h0E : 8'h0F);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
